// File: rtl/bpsk_tx_pkg.sv
// bpsk_tx_pkg: shared states and constants for the BPSK transmit framing path
package bpsk_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD, S_CRC} state_e;
  localparam int BYTE_W = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, init 0) with synchronous clear
module crc8_serial
  import bpsk_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) crc <= '0;
    else if (en) crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
  end
endmodule

// File: rtl/bpsk_frame_serializer.sv
// bpsk_frame_serializer: preamble/sync/payload (+CRC-8 when BPSK_FRAME_CRC_EN) serializer, one bit per symbol
module bpsk_frame_serializer
  import bpsk_tx_pkg::*;
#(
  parameter int          SAMPLES_PER_SYMBOL = 20,
  parameter int          PREAMBLE_LEN       = 32,
  parameter logic [15:0] SYNC_WORD          = DEFAULT_SYNC_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun_err
);
  localparam int SW = $clog2(SAMPLES_PER_SYMBOL);
  localparam int BW = $clog2(PREAMBLE_LEN > 16 ? PREAMBLE_LEN : 16);
  localparam logic [SW-1:0] SYM_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(PREAMBLE_LEN - 1);
  localparam logic [BW-1:0] SYNC_LAST = BW'(15);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_W - 1);
  state_e state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d, shift_q, shift_d;
  logic hold_full_q, hold_full_d, hold_last_q, hold_last_d, last_acc_q, last_acc_d;
  logic shift_last_q, shift_last_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, busy_q, s_ready_q, s_ready_d;
  logic frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic accept, sym_wrap, load, clr;
  logic [3:0] sync_idx;
  logic [7:0] crc;
  assign accept = s_valid && s_ready_q;
  assign sym_wrap = (sym_q == SYM_LAST);
`ifdef BPSK_FRAME_CRC_EN
  crc8_serial u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_IDLE),
    .en   (sym_wrap && state_d == S_PAYLOAD),
    .din  (bit_out_d),
    .crc  (crc)
  );
`else
  assign crc = '0;
`endif
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    last_acc_d = last_acc_q;
    shift_d = shift_q;
    shift_last_d = shift_last_q;
    sym_d = (state_q == S_IDLE || sym_wrap) ? '0 : sym_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    bit_out_d = bit_out_q;
    bit_valid_d = bit_valid_q;
    frame_done_d = 1'b0;
    underrun_d = 1'b0;
    load = 1'b0;
    clr = 1'b0;
    sync_idx = bit_cnt_q[3:0] + 4'd1;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_PREAMBLE;
        bit_out_d = 1'b1;
        bit_valid_d = 1'b1;
      end
      S_PREAMBLE: if (sym_wrap) begin
        state_d = (bit_cnt_q == PRE_LAST) ? S_SYNC : S_PREAMBLE;
        bit_cnt_d = (bit_cnt_q == PRE_LAST) ? '0 : bit_cnt_q + 1'b1;
        bit_out_d = (bit_cnt_q == PRE_LAST) ? SYNC_WORD[15] : ~bit_out_q;
      end
      S_SYNC: if (sym_wrap) begin
        if (bit_cnt_q == SYNC_LAST) load = 1'b1;
        else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          bit_out_d = SYNC_WORD[~sync_idx];
        end
      end
      default: if (sym_wrap) begin
        if (bit_cnt_q != BYTE_LAST) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d = {shift_q[BYTE_W-2:0], 1'b0};
          bit_out_d = shift_q[BYTE_W-2];
        end else if (state_q == S_PAYLOAD && !shift_last_q) begin
          load = hold_full_q;
          clr = !hold_full_q;
          underrun_d = !hold_full_q;
        end
`ifdef BPSK_FRAME_CRC_EN
        else if (state_q == S_PAYLOAD) begin
          state_d = S_CRC;
          bit_cnt_d = '0;
          shift_d = crc;
          bit_out_d = crc[7];
        end
`endif
        else begin
          frame_done_d = 1'b1;
          clr = 1'b1;
        end
      end
    endcase
    if (load) begin
      state_d = S_PAYLOAD;
      bit_cnt_d = '0;
      shift_d = hold_q;
      shift_last_d = hold_last_q;
      hold_full_d = 1'b0;
      bit_out_d = hold_q[BYTE_W-1];
    end
    if (accept && !clr) begin
      hold_d = s_data;
      hold_full_d = 1'b1;
      hold_last_d = s_last;
      last_acc_d = last_acc_q | s_last;
    end
    if (clr) begin
      state_d = S_IDLE;
      hold_d = '0;
      hold_full_d = 1'b0;
      hold_last_d = 1'b0;
      last_acc_d = 1'b0;
      shift_d = '0;
      shift_last_d = 1'b0;
      sym_d = '0;
      bit_cnt_d = '0;
      bit_out_d = 1'b0;
      bit_valid_d = 1'b0;
    end
    s_ready_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD && !hold_full_d && !last_acc_d);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      last_acc_q <= 1'b0;
      shift_q <= '0;
      shift_last_q <= 1'b0;
      sym_q <= '0;
      bit_cnt_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q <= 1'b0;
      s_ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      last_acc_q <= last_acc_d;
      shift_q <= shift_d;
      shift_last_q <= shift_last_d;
      sym_q <= sym_d;
      bit_cnt_q <= bit_cnt_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q <= (state_d != S_IDLE);
      s_ready_q <= s_ready_d;
      frame_done_q <= frame_done_d;
      underrun_q <= underrun_d;
    end
  end
  assign s_ready = s_ready_q;
  assign bit_out = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign underrun_err = underrun_q;
endmodule

// File: tb/tb_bpsk_frame_serializer.sv
// tb_bpsk_frame_serializer: directed self-checking bench for bpsk_frame_serializer
module tb_bpsk_frame_serializer;
  localparam int SPS = 4;
`ifdef BPSK_FRAME_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int NB1 = 32 + CRC_BITS;
  localparam int NB3 = 48 + CRC_BITS;
  localparam int NB4 = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, bit_out, bit_valid, busy, frame_done, underrun_err;
  int total = 0;
  int bad = 0;
  logic cap_out [0:299];
  logic cap_val [0:299];
  logic cap_busy [0:299];
  logic cap_rdy [0:299];
  logic cap_done [0:299];
  logic cap_und [0:299];
  logic cap_acc [0:299];
  always #5 clk = ~clk;
  bpsk_frame_serializer #(
    .SAMPLES_PER_SYMBOL(SPS),
    .PREAMBLE_LEN(8),
    .SYNC_WORD(16'hD391)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .busy(busy),
    .frame_done(frame_done),
    .underrun_err(underrun_err)
  );
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk);
  endtask
  task automatic drop_valid();
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      cap_out[i] = bit_out;
      cap_val[i] = bit_valid;
      cap_busy[i] = busy;
      cap_rdy[i] = s_ready;
      cap_done[i] = frame_done;
      cap_und[i] = underrun_err;
      cap_acc[i] = s_valid && s_ready;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bit_out, bit_valid, busy, s_ready, frame_done, underrun_err} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 000000", {bit_out, bit_valid, busy, s_ready, frame_done, underrun_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bit_out, bit_valid, busy, s_ready, frame_done, underrun_err} !== 6'b000100) begin
      bad++;
      $display("FAIL ready_after_reset: got %b required 000100", {bit_out, bit_valid, busy, s_ready, frame_done, underrun_err});
    end
  endtask
  task automatic test_single_byte();
    logic [NB1-1:0] e;
    int nd;
    logic ok;
`ifdef BPSK_FRAME_CRC_EN
    e = {8'b10101010, 16'b1101001110010001, 8'b10100101, 8'b01110010};
`else
    e = {8'b10101010, 16'b1101001110010001, 8'b10100101};
`endif
    send_byte(8'hA5, 1'b1);
    fork
      drop_valid();
      capture(NB1 * SPS + 2);
    join
    for (int k = 0; k < NB1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < SPS; j++)
        if (cap_out[k*SPS+j] !== e[NB1-1-k] || cap_val[k*SPS+j] !== 1'b1) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL single_bit%0d: got out=%b valid=%b required out=%b valid=1", k, cap_out[k*SPS], cap_val[k*SPS], e[NB1-1-k]);
      end
    end
    nd = 0;
    for (int i = 0; i < NB1 * SPS; i++) if (cap_done[i] || cap_und[i]) nd++;
    total++;
    if (nd != 0) begin
      bad++;
      $display("FAIL single_early_pulse: got %0d pulse cycles required 0", nd);
    end
    total++;
    if ({cap_done[NB1*SPS], cap_und[NB1*SPS], cap_val[NB1*SPS], cap_busy[NB1*SPS], cap_rdy[NB1*SPS], cap_out[NB1*SPS]} !== 6'b100010) begin
      bad++;
      $display("FAIL single_end: got done/und/val/busy/rdy/out=%b required 100010",
               {cap_done[NB1*SPS], cap_und[NB1*SPS], cap_val[NB1*SPS], cap_busy[NB1*SPS], cap_rdy[NB1*SPS], cap_out[NB1*SPS]});
    end
    total++;
    if (cap_done[NB1*SPS+1] !== 1'b0) begin
      bad++;
      $display("FAIL single_done_width: got %b required 0", cap_done[NB1*SPS+1]);
    end
  endtask
  task automatic test_backpressure();
    logic [NB3-1:0] e;
    int nr, na;
    logic ok;
`ifdef BPSK_FRAME_CRC_EN
    e = {8'hAA, 16'hD391, 8'h00, 8'hFF, 8'h3C, 8'h63};
`else
    e = {8'hAA, 16'hD391, 8'h00, 8'hFF, 8'h3C};
`endif
    send_byte(8'h00, 1'b0);
    fork
      begin
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3C, 1'b1);
        drop_valid();
      end
      capture(NB3 * SPS + 2);
    join
    nr = 0;
    for (int i = 0; i < 24 * SPS; i++) if (cap_rdy[i] !== 1'b0) nr++;
    total++;
    if (nr != 0) begin
      bad++;
      $display("FAIL bp_ready_low: got %0d ready cycles in preamble/sync required 0", nr);
    end
    na = 0;
    for (int i = 0; i < NB3 * SPS + 2; i++) if (cap_acc[i]) na++;
    total++;
    if (na != 2 || cap_acc[24*SPS] !== 1'b1 || cap_acc[32*SPS] !== 1'b1) begin
      bad++;
      $display("FAIL bp_transfers: got count=%0d at96=%b at128=%b required 2 1 1", na, cap_acc[24*SPS], cap_acc[32*SPS]);
    end
    for (int k = 0; k < NB3; k++) begin
      ok = 1'b1;
      for (int j = 0; j < SPS; j++)
        if (cap_out[k*SPS+j] !== e[NB3-1-k] || cap_val[k*SPS+j] !== 1'b1) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL bp_bit%0d: got out=%b valid=%b required out=%b valid=1", k, cap_out[k*SPS], cap_val[k*SPS], e[NB3-1-k]);
      end
    end
    total++;
    if ({cap_done[NB3*SPS], cap_und[NB3*SPS], cap_val[NB3*SPS], cap_busy[NB3*SPS], cap_rdy[NB3*SPS]} !== 5'b10001) begin
      bad++;
      $display("FAIL bp_end: got done/und/val/busy/rdy=%b required 10001",
               {cap_done[NB3*SPS], cap_und[NB3*SPS], cap_val[NB3*SPS], cap_busy[NB3*SPS], cap_rdy[NB3*SPS]});
    end
  endtask
  task automatic test_underrun();
    logic [NB4-1:0] e;
    int nd;
    logic ok;
    e = {8'hAA, 16'hD391, 8'h01};
    send_byte(8'h01, 1'b0);
    fork
      drop_valid();
      capture(NB4 * SPS + 2);
    join
    for (int k = 0; k < NB4; k++) begin
      ok = 1'b1;
      for (int j = 0; j < SPS; j++)
        if (cap_out[k*SPS+j] !== e[NB4-1-k] || cap_val[k*SPS+j] !== 1'b1) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL underrun_bit%0d: got out=%b valid=%b required out=%b valid=1", k, cap_out[k*SPS], cap_val[k*SPS], e[NB4-1-k]);
      end
    end
    total++;
    if ({cap_done[NB4*SPS], cap_und[NB4*SPS], cap_val[NB4*SPS], cap_busy[NB4*SPS], cap_out[NB4*SPS]} !== 5'b01000) begin
      bad++;
      $display("FAIL underrun_end: got done/und/val/busy/out=%b required 01000",
               {cap_done[NB4*SPS], cap_und[NB4*SPS], cap_val[NB4*SPS], cap_busy[NB4*SPS], cap_out[NB4*SPS]});
    end
    nd = 0;
    for (int i = 0; i < NB4 * SPS + 2; i++) if (cap_done[i]) nd++;
    total++;
    if (nd != 0 || cap_und[NB4*SPS+1] !== 1'b0) begin
      bad++;
      $display("FAIL underrun_pulses: got done_cycles=%0d und_next=%b required 0 0", nd, cap_und[NB4*SPS+1]);
    end
  endtask
  task automatic test_reset_mid_frame();
    int k;
    send_byte(8'h5A, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (busy !== 1'b1 || bit_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_before: got busy=%b valid=%b required 1 1", busy, bit_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bit_out, bit_valid, busy, s_ready, frame_done, underrun_err} !== 6'b000000) begin
      bad++;
      $display("FAIL midrst_cleared: got %b required 000000", {bit_out, bit_valid, busy, s_ready, frame_done, underrun_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bit_out, bit_valid, busy, s_ready, frame_done, underrun_err} !== 6'b000100) begin
      bad++;
      $display("FAIL midrst_release: got %b required 000100", {bit_out, bit_valid, busy, s_ready, frame_done, underrun_err});
    end
    send_byte(8'hC3, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if ({bit_valid, bit_out, busy} !== 3'b111) begin
      bad++;
      $display("FAIL midrst_restart: got valid/out/busy=%b required 111", {bit_valid, bit_out, busy});
    end
    k = 0;
    while (!frame_done && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != NB1 * SPS) begin
      bad++;
      $display("FAIL midrst_frame_len: got done after %0d cycles required %0d", k, NB1 * SPS);
    end
  endtask
  task automatic test_back_to_back();
    int k;
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    k = 0;
    while (!frame_done && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != NB1 * SPS || s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_end: got cycles=%0d ready=%b busy=%b required %0d 1 0", k, s_ready, busy, NB1 * SPS);
    end
    s_data = 8'h3C;
    s_last = 1'b1;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    total++;
    if ({bit_valid, bit_out, busy, frame_done} !== 4'b1110) begin
      bad++;
      $display("FAIL b2b_restart: got valid/out/busy/done=%b required 1110", {bit_valid, bit_out, busy, frame_done});
    end
    k = 0;
    while (!frame_done && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k != NB1 * SPS) begin
      bad++;
      $display("FAIL b2b_second_len: got done after %0d cycles required %0d", k, NB1 * SPS);
    end
  endtask
  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_underrun();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
